// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA memory subsystem.
// The owner tag says who a memory access belongs to.
package vga_pkg;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_DISP,
    OWN_BUSW,
    OWN_BUSR
  } owner_e;

  localparam logic [14:0] BUF_BASE = 15'h4000;
  localparam logic [14:0] ROM_BASE = 15'h1000;
  localparam logic [14:0] REG_BASE = 15'h2000;

endpackage

// File: rtl/vga_arb_slot.sv
// One-deep pending slot for a bus request.
// Includes a saturating wait counter and flags for starvation and dropped requests.
module vga_arb_slot #(
  parameter int unsigned W        = 12,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         req_i,
  input  logic [W-1:0] payload_i,
  input  logic         issue_i,
  output logic         pending_o,
  output logic [W-1:0] payload_o,
  output logic         drop_o,
  output logic         starve_o
);

  localparam int unsigned CntW = $clog2(MAX_WAIT + 1);

  logic            pending_q, pending_d;
  logic [W-1:0]    payload_q, payload_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            capture;

  // A slot that is being issued this cycle can take a new request at once.
  assign capture = req_i & (~pending_q | issue_i);

  always_comb begin
    pending_d = pending_q;
    payload_d = payload_q;
    cnt_d     = cnt_q;
    if (capture) begin
      pending_d = 1'b1;
      payload_d = payload_i;
      cnt_d     = '0;
    end else if (issue_i) begin
      pending_d = 1'b0;
      cnt_d     = '0;
    end else if (pending_q && (cnt_q != CntW'(MAX_WAIT))) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pending_q <= 1'b0;
      payload_q <= '0;
      cnt_q     <= '0;
    end else begin
      pending_q <= pending_d;
      payload_q <= payload_d;
      cnt_q     <= cnt_d;
    end
  end

  assign pending_o = pending_q;
  assign payload_o = payload_q;
  assign drop_o    = req_i & pending_q & ~issue_i;
  // Fires once, on the cycle the counter reaches saturation.
  assign starve_o  = pending_q & ~issue_i & (cnt_q == CntW'(MAX_WAIT - 1));

endmodule

// File: rtl/vga_mem_arbiter.sv
// Single-port memory arbiter that gives display fetches absolute priority.
// Bus writes, then bus reads, are issued in the free cycles.
module vga_mem_arbiter
  import vga_pkg::*;
#(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned RD_LAT   = 1
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              disp_req_i,
  input  logic [ADDR_W-1:0] disp_addr_i,
  output logic [DATA_W-1:0] disp_data_o,
  output logic              disp_valid_o,
  input  logic              bus_wreq_i,
  input  logic [ADDR_W-1:0] bus_waddr_i,
  input  logic [DATA_W-1:0] bus_wdata_i,
  output logic              bus_wbusy_o,
  input  logic              bus_rreq_i,
  input  logic [ADDR_W-1:0] bus_raddr_i,
  output logic              bus_rbusy_o,
  output logic [DATA_W-1:0] bus_rdata_o,
  output logic              bus_rvalid_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              clr_i,
  output logic              starve_o,
  output logic              drop_o
);

  localparam int unsigned WPayW = ADDR_W + DATA_W;

  logic              w_pending, r_pending;
  logic [WPayW-1:0]  w_payload;
  logic [ADDR_W-1:0] r_addr;
  logic              w_drop, r_drop, w_starve, r_starve;
  logic              gnt_w, gnt_r;
  owner_e            own_in, own_out;
  owner_e            own_q [RD_LAT];
  logic [DATA_W-1:0] bus_rdata_q;
  logic              bus_rvalid_q, starve_q, drop_q;

  assign gnt_w = ~disp_req_i & w_pending;
  assign gnt_r = ~disp_req_i & ~w_pending & r_pending;

  vga_arb_slot #(
    .W        (WPayW),
    .MAX_WAIT (MAX_WAIT)
  ) u_wslot (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .req_i     (bus_wreq_i),
    .payload_i ({bus_waddr_i, bus_wdata_i}),
    .issue_i   (gnt_w),
    .pending_o (w_pending),
    .payload_o (w_payload),
    .drop_o    (w_drop),
    .starve_o  (w_starve)
  );

  vga_arb_slot #(
    .W        (ADDR_W),
    .MAX_WAIT (MAX_WAIT)
  ) u_rslot (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .req_i     (bus_rreq_i),
    .payload_i (bus_raddr_i),
    .issue_i   (gnt_r),
    .pending_o (r_pending),
    .payload_o (r_addr),
    .drop_o    (r_drop),
    .starve_o  (r_starve)
  );

  // Grant mux is combinational so a display fetch reaches memory in its own cycle.
  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    own_in      = OWN_NONE;
    if (disp_req_i) begin
      mem_en_o   = 1'b1;
      mem_addr_o = disp_addr_i;
      own_in     = OWN_DISP;
    end else if (gnt_w) begin
      mem_en_o    = 1'b1;
      mem_we_o    = 1'b1;
      mem_addr_o  = w_payload[WPayW-1:DATA_W];
      mem_wdata_o = w_payload[DATA_W-1:0];
      own_in      = OWN_BUSW;
    end else if (gnt_r) begin
      mem_en_o   = 1'b1;
      mem_addr_o = r_addr;
      own_in     = OWN_BUSR;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < RD_LAT; i++) own_q[i] <= OWN_NONE;
    end else begin
      own_q[0] <= own_in;
      for (int i = 1; i < RD_LAT; i++) own_q[i] <= own_q[i-1];
    end
  end

  assign own_out      = own_q[RD_LAT-1];
  assign disp_valid_o = (own_out == OWN_DISP);
  assign disp_data_o  = disp_valid_o ? mem_rdata_i : '0;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      bus_rdata_q  <= '0;
      bus_rvalid_q <= 1'b0;
      starve_q     <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      bus_rvalid_q <= (own_out == OWN_BUSR);
      if (own_out == OWN_BUSR) bus_rdata_q <= mem_rdata_i;
      // A set event in the same cycle as clr_i wins.
      starve_q <= w_starve | r_starve | (starve_q & ~clr_i);
      drop_q   <= w_drop | r_drop | (drop_q & ~clr_i);
    end
  end

  assign bus_wbusy_o  = w_pending;
  assign bus_rbusy_o  = r_pending;
  assign bus_rdata_o  = bus_rdata_q;
  assign bus_rvalid_o = bus_rvalid_q;
  assign starve_o     = starve_q;
  assign drop_o       = drop_q;

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Scoreboard bench for vga_mem_arbiter: the driver runs a reference model and queues
// expected responses, while a negedge monitor compares them against the DUT outputs.
module tb_vga_mem_arbiter;

  localparam int MAX_WAIT = 15;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        disp_req = 1'b0, bus_wreq = 1'b0, bus_rreq = 1'b0, clr = 1'b0;
  logic [11:0] disp_addr = '0, bus_waddr = '0, bus_raddr = '0;
  logic [7:0]  bus_wdata = '0;
  logic [7:0]  disp_data, bus_rdata, mem_wdata;
  logic [7:0]  mem_rdata = '0;
  logic [11:0] mem_addr;
  logic        disp_valid, bus_wbusy, bus_rbusy, bus_rvalid, mem_en, mem_we, starve, drop;

  always #5 clk = ~clk;

  vga_mem_arbiter #(
    .ADDR_W   (12),
    .DATA_W   (8),
    .MAX_WAIT (MAX_WAIT),
    .RD_LAT   (1)
  ) dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .disp_req_i   (disp_req),
    .disp_addr_i  (disp_addr),
    .disp_data_o  (disp_data),
    .disp_valid_o (disp_valid),
    .bus_wreq_i   (bus_wreq),
    .bus_waddr_i  (bus_waddr),
    .bus_wdata_i  (bus_wdata),
    .bus_wbusy_o  (bus_wbusy),
    .bus_rreq_i   (bus_rreq),
    .bus_raddr_i  (bus_raddr),
    .bus_rbusy_o  (bus_rbusy),
    .bus_rdata_o  (bus_rdata),
    .bus_rvalid_o (bus_rvalid),
    .mem_en_o     (mem_en),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_rdata_i  (mem_rdata),
    .clr_i        (clr),
    .starve_o     (starve),
    .drop_o       (drop)
  );

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 37 + 11) ^ (i >> 4));
  endfunction

  // Synchronous BRAM, preloaded with a known pattern while reset is held.
  logic [7:0] bram [4096];
  always @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < 4096; i++) bram[i] <= pat(i);
    end else if (mem_en) begin
      if (mem_we) bram[mem_addr] <= mem_wdata;
      else        mem_rdata <= bram[mem_addr];
    end
  end

  typedef struct {
    int          cyc;
    logic        rst;
    logic        en, we;
    logic [11:0] addr;
    logic [7:0]  wdata;
    logic        wbusy, rbusy, starve, drop;
  } cyc_rec_t;

  typedef struct {
    int         cyc;
    logic [7:0] data;
  } resp_t;

  cyc_rec_t exp_cyc_q [$];
  resp_t    exp_disp_q [$];
  resp_t    exp_rd_q [$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model state.
  logic [7:0]  shadow [4096];
  logic        m_wp, m_rp, m_starve, m_drop;
  logic [11:0] m_waddr, m_raddr;
  logic [7:0]  m_wdata;
  int          m_wwait, m_rwait;

  task automatic chk(input string name, input int c, input logic [31:0] act,
                     input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", name, c, act, expv);
    end
  endtask

  task automatic model_reset();
    m_wp = 1'b0; m_rp = 1'b0; m_starve = 1'b0; m_drop = 1'b0;
    m_waddr = '0; m_raddr = '0; m_wdata = '0; m_wwait = 0; m_rwait = 0;
    for (int i = 0; i < 4096; i++) shadow[i] = pat(i);
  endtask

  task automatic slot_upd(input logic req, input logic iss, inout logic pend, inout int waitc,
                          output logic cap, output logic drp, output logic stv);
    cap = req && (!pend || iss);
    drp = req && pend && !iss;
    stv = 1'b0;
    if (cap) begin
      pend = 1'b1; waitc = 0;
    end else if (iss) begin
      pend = 1'b0; waitc = 0;
    end else if (pend && waitc < MAX_WAIT) begin
      waitc++;
      stv = (waitc == MAX_WAIT);
    end
  endtask

  // Drive one cycle of inputs, predict that cycle, then advance to just after the edge.
  task automatic step(input logic rst, input logic dreq, input logic [11:0] daddr,
                      input logic wreq, input logic [11:0] waddr, input logic [7:0] wdata,
                      input logic rreq, input logic [11:0] raddr, input logic clr_in);
    cyc_rec_t r;
    resp_t    p;
    logic     w_iss, r_iss, cap, drp, stv, sset, dset;
    rstn = !rst; disp_req = dreq; disp_addr = daddr;
    bus_wreq = wreq; bus_waddr = waddr; bus_wdata = wdata;
    bus_rreq = rreq; bus_raddr = raddr; clr = clr_in;
    r = '{cyc: cyc, rst: rst, en: 1'b0, we: 1'b0, addr: '0, wdata: '0,
          wbusy: 1'b0, rbusy: 1'b0, starve: 1'b0, drop: 1'b0};
    if (rst) begin
      model_reset();
      exp_disp_q.delete();
      exp_rd_q.delete();
    end else begin
      r.wbusy = m_wp; r.rbusy = m_rp; r.starve = m_starve; r.drop = m_drop;
      w_iss = !dreq && m_wp;
      r_iss = !dreq && !m_wp && m_rp;
      if (dreq) begin
        r.en = 1'b1; r.addr = daddr;
        p.cyc = cyc + 1; p.data = shadow[daddr]; exp_disp_q.push_back(p);
      end else if (w_iss) begin
        r.en = 1'b1; r.we = 1'b1; r.addr = m_waddr; r.wdata = m_wdata;
        shadow[m_waddr] = m_wdata;
      end else if (r_iss) begin
        r.en = 1'b1; r.addr = m_raddr;
        p.cyc = cyc + 2; p.data = shadow[m_raddr]; exp_rd_q.push_back(p);
      end
      slot_upd(wreq, w_iss, m_wp, m_wwait, cap, drp, stv);
      if (cap) begin m_waddr = waddr; m_wdata = wdata; end
      sset = stv; dset = drp;
      slot_upd(rreq, r_iss, m_rp, m_rwait, cap, drp, stv);
      if (cap) m_raddr = raddr;
      sset = sset || stv; dset = dset || drp;
      m_starve = sset || (m_starve && !clr_in);
      m_drop   = dset || (m_drop && !clr_in);
    end
    exp_cyc_q.push_back(r);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 12'h0, 1'b0, 12'h0, 8'h0, 1'b0, 12'h0, 1'b0);
  endtask

  // Monitor: compares every cycle's outputs and pops responses as the DUT presents them.
  logic [7:0] last_rd = '0;
  always @(negedge clk) begin
    cyc_rec_t r;
    logic     exp_now;
    if (exp_cyc_q.size() > 0) begin
      r = exp_cyc_q.pop_front();
      if (r.rst) last_rd = '0;
      chk("mem_en", r.cyc, 32'(mem_en), 32'(r.en));
      chk("mem_we", r.cyc, 32'(mem_we), 32'(r.we));
      if (r.en) chk("mem_addr", r.cyc, 32'(mem_addr), 32'(r.addr));
      if (r.we) chk("mem_wdata", r.cyc, 32'(mem_wdata), 32'(r.wdata));
      chk("wbusy", r.cyc, 32'(bus_wbusy), 32'(r.wbusy));
      chk("rbusy", r.cyc, 32'(bus_rbusy), 32'(r.rbusy));
      chk("starve", r.cyc, 32'(starve), 32'(r.starve));
      chk("drop", r.cyc, 32'(drop), 32'(r.drop));
      exp_now = (exp_disp_q.size() > 0) && (exp_disp_q[0].cyc == r.cyc);
      chk("disp_valid", r.cyc, 32'(disp_valid), 32'(exp_now));
      if (exp_now) begin
        chk("disp_data", r.cyc, 32'(disp_data), 32'(exp_disp_q[0].data));
        void'(exp_disp_q.pop_front());
      end
      exp_now = (exp_rd_q.size() > 0) && (exp_rd_q[0].cyc == r.cyc);
      chk("bus_rvalid", r.cyc, 32'(bus_rvalid), 32'(exp_now));
      if (exp_now) begin
        last_rd = exp_rd_q[0].data;
        void'(exp_rd_q.pop_front());
      end
      chk("bus_rdata", r.cyc, 32'(bus_rdata), 32'(last_rd));
    end
  end

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    repeat (2) step(1'b1, 1'b0, 12'h0, 1'b0, 12'h0, 8'h0, 1'b0, 12'h0, 1'b0);
    idle(3);

    // Single bus write on an idle arbiter.
    step(1'b0, 1'b0, 12'h0, 1'b1, 12'h05F, 8'h41, 1'b0, 12'h0, 1'b0);
    idle(3);

    // Write starved by 20 display cycles, then issued; stickies cleared afterwards.
    step(1'b0, 1'b0, 12'h0, 1'b1, 12'h020, 8'h5A, 1'b0, 12'h0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      logic [11:0] a;
      a = 12'($urandom_range(0, 4095));
      step(1'b0, 1'b1, a, 1'b0, 12'h0, 8'h0, 1'b0, 12'h0, 1'b0);
    end
    idle(2);
    step(1'b0, 1'b0, 12'h0, 1'b0, 12'h0, 8'h0, 1'b0, 12'h0, 1'b1);
    idle(2);

    // Same-cycle write and read to one address.
    step(1'b0, 1'b0, 12'h0, 1'b1, 12'h010, 8'hFF, 1'b1, 12'h010, 1'b0);
    idle(5);

    // Second write while the first is held behind a display fetch.
    step(1'b0, 1'b0, 12'h0, 1'b1, 12'h030, 8'h11, 1'b0, 12'h0, 1'b0);
    step(1'b0, 1'b1, 12'h123, 1'b1, 12'h031, 8'h22, 1'b0, 12'h0, 1'b0);
    idle(3);
    step(1'b0, 1'b0, 12'h0, 1'b0, 12'h0, 8'h0, 1'b0, 12'h0, 1'b1);
    idle(2);

    // Reset the cycle after a bus read is issued.
    step(1'b0, 1'b0, 12'h0, 1'b0, 12'h0, 8'h0, 1'b1, 12'h030, 1'b0);
    idle(1);
    repeat (2) step(1'b1, 1'b0, 12'h0, 1'b0, 12'h0, 8'h0, 1'b0, 12'h0, 1'b0);
    idle(3);

    // Display every other cycle with back-to-back bus reads.
    for (int i = 0; i < 16; i++) begin
      logic [11:0] da, ra;
      da = 12'($urandom_range(0, 4095));
      ra = 12'($urandom_range(0, 63));
      step(1'b0, (i % 2) == 0, da, 1'b0, 12'h0, 8'h0, 1'b1, ra, 1'b0);
    end
    idle(4);

    // Randomised traffic on a small address window to exercise read-after-write.
    for (int i = 0; i < 3000; i++) begin
      logic [11:0] da, wa, ra;
      logic [7:0]  wd;
      logic        dq, wq, rq, cl;
      da = 12'($urandom_range(0, 15));
      wa = 12'($urandom_range(0, 15));
      ra = 12'($urandom_range(0, 15));
      wd = 8'($urandom_range(0, 255));
      dq = ($urandom_range(0, 9) < 4);
      wq = ($urandom_range(0, 9) < 2);
      rq = ($urandom_range(0, 9) < 2);
      cl = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 999) == 0)
        step(1'b1, 1'b0, 12'h0, 1'b0, 12'h0, 8'h0, 1'b0, 12'h0, 1'b0);
      else
        step(1'b0, dq, da, wq, wa, wd, rq, ra, cl);
    end
    idle(6);

    chk("disp_drain", cyc, 32'(exp_disp_q.size()), 32'd0);
    chk("rd_drain", cyc, 32'(exp_rd_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
